fetch_sequencer: RTL

//  Sequences instruction fetch for the pipelined MIPS core. Owns the PC, issues req/rdy reads to

---
 rtl/mips_pkg.sv | 20 ++
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/fetch_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: the fetch FSM encoding, the
// default reset vector and the instruction/PC widths.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, PC} holding register that catches a returned instruction
// when decode is stalled and the output slot is still occupied.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_unload,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_full;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc;

  // clear (flush) wins over a same-cycle load so a discarded word never lands here
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_full  <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_full  <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the imem req/rdy read port
// and feeds the F/D register, with skid buffering and redirect flushing.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_D,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_PC,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr_F,
  output logic [XLEN-1:0] PC_F,
  output logic [XLEN-1:0] PCPlus4_F,
  output logic            valid_F,
  output logic            timeout_err,
  output fetch_state_e    o_dbg_state
);

  // Handshakes: imem read completes on a cycle with imem_req && imem_rdy, and
  // imem_req/imem_addr stay stable until then. Decode takes the F/D word on a
  // cycle with valid_F && !stall_D; instr_F/PC_F are held while stalled.

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_drain_addr;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_f;
  logic [XLEN-1:0] r_pcp4_f;
  logic            r_valid;
  logic [7:0]      r_wait_cnt;
  logic            r_timeout;

  logic            w_accept;
  logic            w_req;
  logic            w_capture;
  logic            w_skid_load;
  logic            w_skid_unload;
  logic            w_skid_full;
  logic [XLEN-1:0] w_skid_instr;
  logic [XLEN-1:0] w_skid_pc;
  logic [XLEN-1:0] w_target;

  assign w_accept      = !r_valid || !stall_D;
  assign w_req         = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_capture     = (r_state == ST_FETCH) && imem_rdy && !redirect;
  assign w_skid_load   = w_capture && !w_accept;
  assign w_skid_unload = (r_state == ST_HOLD) && w_skid_full && w_accept && !redirect;
  assign w_target      = word_align(redirect_PC);

  fetch_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (redirect),
    .i_instr  (imem_rdata),
    .i_pc     (r_pc),
    .o_full   (w_skid_full),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_instr      <= NOP_INSTR;
      r_pc_f       <= '0;
      r_pcp4_f     <= '0;
      r_valid      <= 1'b0;
      r_wait_cnt   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      // The wait count follows the bus request, so it keeps counting through DRAIN.
      if (w_req && !imem_rdy) begin
        if (r_wait_cnt < MAX_WAIT_C) r_wait_cnt <= r_wait_cnt + 8'd1;
        if (r_wait_cnt + 8'd1 >= MAX_WAIT_C) r_timeout <= 1'b1;
      end else begin
        r_wait_cnt <= '0;
      end

      if (redirect) begin
        r_valid <= 1'b0;
      end else if (w_capture && w_accept) begin
        r_instr  <= imem_rdata;
        r_pc_f   <= r_pc;
        r_pcp4_f <= r_pc + 32'd4;
        r_valid  <= 1'b1;
      end else if (w_skid_unload) begin
        r_instr  <= w_skid_instr;
        r_pc_f   <= w_skid_pc;
        r_pcp4_f <= w_skid_pc + 32'd4;
        r_valid  <= 1'b1;
      end else if (r_valid && !stall_D) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_state <= ST_FETCH;
          if (redirect) r_pc <= w_target;
        end
        ST_FETCH: begin
          if (redirect) begin
            r_pc <= w_target;
            if (!imem_rdy) begin
              r_state      <= ST_DRAIN;
              r_drain_addr <= r_pc;
            end
          end else if (imem_rdy) begin
            r_pc <= r_pc + 32'd4;
            if (!w_accept) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            r_pc    <= w_target;
            r_state <= ST_FETCH;
          end else if (w_skid_unload) begin
            r_state <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // Stale read completes here and its data is dropped.
          if (redirect) r_pc <= w_target;
          if (imem_rdy) r_state <= ST_FETCH;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = (r_state == ST_DRAIN) ? r_drain_addr : r_pc;
  assign instr_F     = r_instr;
  assign PC_F        = r_pc_f;
  assign PCPlus4_F   = r_pcp4_f;
  assign valid_F     = r_valid;
  assign timeout_err = r_timeout;
  assign o_dbg_state = r_state;

endmodule
